// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the request/response handshake from the MEM stage and the
// word-addressed data-memory bus of mem_access_unit.
//   slave  modport : the access unit itself (consumes requests, drives memory)
//   master modport : the MEM stage / memory side (issues requests, serves reads)
// Signals:
//   req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata
//   rsp_valid/rsp_rdata/rsp_err
//   mem_address/mem_writeData/mem_memRead/mem_memWrite/mem_rdata
// ----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_writeData;
    logic                  mem_memRead;
    logic                  mem_memWrite;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_writeData, mem_memRead, mem_memWrite
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_writeData, mem_memRead, mem_memWrite
    );
endinterface

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the word-addressed data memory. Accepts byte/half/word
// loads and stores, performs read-modify-write for sub-word stores and lane
// extraction with sign/zero extension for sub-word loads. One response per
// accepted request.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - mem_access_unit_if.slave (request, response and memory bus)
// Parameters:
//   ADDR_WIDTH - request/memory address width
//   RD_WAIT    - extra RD cycles before the read word is captured (0..15)
// Build option:
//   MEM_ALIGN_CHECK_EN - when defined, misaligned half/word requests skip
//   memory and respond with rsp_err=1; otherwise addresses are aligned down.
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_WAIT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  write_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word_q, word_d;
    logic [3:0]            wait_q, wait_d;

    logic                  accept;
    logic                  mis_in;
    logic                  mis_held;
    logic [31:0]           merged;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_data;

    assign accept = bus.req_valid && (state_q == S_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in   = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign mis_held = ((size_q == 2'b01) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign mis_in   = 1'b0;
    assign mis_held = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            wait_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wait_q  <= wait_d;
            if (accept) begin
                addr_q   <= bus.req_addr;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                write_q  <= bus.req_write;
                wdata_q  <= bus.req_wdata;
            end
        end
    end

    // Next-state logic. Word stores skip RD; sub-word stores need the old
    // word first so the untouched lanes can be written back unchanged.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                wait_d = 4'd0;
                if (accept) begin
                    if (mis_in)                                 state_d = S_RESP;
                    else if (!bus.req_write)                    state_d = S_RD;
                    else if (bus.req_size[1])                   state_d = S_WR;
                    else                                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (wait_q == 4'(RD_WAIT)) begin
                    word_d  = bus.mem_rdata;
                    state_d = write_q ? S_WR : S_RESP;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Store merge: each byte lane picks new data or keeps the old word.
    // Reserved size 2'b11 behaves as a word (size_q[1] set).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic byte_hit;
            logic half_hit;
            assign byte_hit = (size_q == 2'b00) && (addr_q[1:0] == 2'(gi));
            assign half_hit = (size_q == 2'b01) && (addr_q[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = size_q[1] ? wdata_q[8*gi +: 8] :
                                       byte_hit  ? wdata_q[7:0] :
                                       half_hit  ? wdata_q[8*(gi%2) +: 8] :
                                                   word_q[8*gi +: 8];
        end
    endgenerate

    assign lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = word_q[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = word_q;
        case (size_q)
            2'b00:   load_data = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
            2'b01:   load_data = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
            default: load_data = word_q;
        endcase
    end

    // Outputs: everything idles at zero; the write strobe is gated by rst so
    // a reset landing in WR never commits a write on that edge.
    always_comb begin
        bus.req_ready     = (state_q == S_IDLE);
        bus.rsp_valid     = 1'b0;
        bus.rsp_rdata     = 32'h0;
        bus.rsp_err       = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writeData = 32'h0;
        bus.mem_memRead   = 1'b0;
        bus.mem_memWrite  = 1'b0;
        case (state_q)
            S_RD: begin
                bus.mem_memRead = 1'b1;
                bus.mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            end
            S_WR: begin
                bus.mem_memWrite  = !rst;
                bus.mem_address   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                bus.mem_writeData = merged;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = mis_held;
                bus.rsp_rdata = (write_q || mis_held) ? 32'h0 : load_data;
            end
            default: ;
        endcase
    end
endmodule
